ascon_perm_dom_iter: RTL and testbench

Iterative, parametrised DOM-masked Ascon permutation p^a with a configurable number of shares.
- Loads a NUM_SHARES-share 320-bit state and runs 1..12 rounds, one round per two clock cycles (DOM register stage inside the S-box).
- Fresh randomness is taken per round through a valid/ready handshake; completion is signalled by a done pulse.
- Sits between the masked AEAD mode controller and the randomness source; replaces the single-round, fixed-two-share round function.

---
 rtl/ascon_perm_dom_iter.sv | 168 ++++++++++++++++
 tb/tb_ascon_perm_dom_iter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_perm_dom_iter.sv
// Iterative DOM-masked Ascon permutation p^a, NUM_SHARES shares, 2 cycles/round.
// Optional macro ASCON_DOM_ZEROIZE_EN: wipe all state the cycle after done.
module ascon_perm_dom_iter #(
    parameter  int NUM_SHARES = 2,
    localparam int RAND_W     = 320 * NUM_SHARES * (NUM_SHARES - 1) / 2
) (
    input  logic                      clk,
    input  logic                      RST,
    input  logic                      start,
    input  logic [3:0]                rounds,
    input  logic [320*NUM_SHARES-1:0] state_in,
    input  logic [RAND_W-1:0]         rand_in,
    input  logic                      rand_valid,
    output logic                      rand_ready,
    output logic [320*NUM_SHARES-1:0] state_out,
    output logic                      busy,
    output logic                      done,
    output logic                      cfg_err
);
    localparam int NS = NUM_SHARES;
    localparam int NP = NS * (NS - 1) / 2;

    if (NS < 2 || NS > 4) begin : g_bad_shares
        $error("ascon_perm_dom_iter: NUM_SHARES must be 2..4");
    end

    typedef logic [4:0][63:0] share_t;
    typedef enum logic [1:0] {IDLE, RUN_A, RUN_B, DONE} state_e;

    state_e                  fsm;
    logic [3:0]              rnd_idx;
    logic [7:0]              rc;
    share_t [NS-1:0]         st_q, st_d, a_q, a_d;
    share_t [NS-1:0][NS-1:0] dom_q, dom_d;
    logic [NP-1:0][4:0][63:0] rbits;

    assign rbits     = rand_in;
    assign state_out = st_q;
    assign rc        = 8'hF0 - 8'(rnd_idx) * 8'h0F;

    function automatic int pidx(int p, int q);
        return p * NS - p * (p + 1) / 2 + (q - p - 1);
    endfunction

    function automatic logic [63:0] ror(logic [63:0] x, int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // First S-box half: constant, pre-layer, DOM inner/cross products
    always_comb begin
        share_t      x;
        logic [63:0] nx;
        a_d   = '0;
        dom_d = '0;
        x     = '0;
        nx    = '0;
        for (int k = 0; k < NS; k++) begin
            x = st_q[k];
            if (k == 0) x[2][7:0] = x[2][7:0] ^ rc;
            a_d[k][0] = x[0] ^ x[4];
            a_d[k][1] = x[1];
            a_d[k][2] = x[2] ^ x[1];
            a_d[k][3] = x[3];
            a_d[k][4] = x[4] ^ x[3];
        end
        for (int p = 0; p < NS; p++) begin
            for (int q = 0; q < NS; q++) begin
                for (int g = 0; g < 5; g++) begin
                    nx = (p == 0) ? ~a_d[p][g] : a_d[p][g];
                    dom_d[p][q][g] = nx & a_d[q][(g+1)%5];
                    if (p < q)
                        dom_d[p][q][g] = dom_d[p][q][g] ^ rbits[pidx(p, q)][g];
                    else if (p > q)
                        dom_d[p][q][g] = dom_d[p][q][g] ^ rbits[pidx(q, p)][g];
                end
            end
        end
    end

    // Second half: per-share compression, post-layer, linear layer
    always_comb begin
        share_t t;
        share_t c;
        st_d = '0;
        t    = '0;
        c    = '0;
        for (int k = 0; k < NS; k++) begin
            t = '0;
            for (int q = 0; q < NS; q++)
                for (int g = 0; g < 5; g++)
                    t[g] = t[g] ^ dom_q[k][q][g];
            for (int g = 0; g < 5; g++)
                c[g] = a_q[k][g] ^ t[(g+1)%5];
            c[1] = c[1] ^ c[0];
            c[0] = c[0] ^ c[4];
            c[3] = c[3] ^ c[2];
            if (k == 0) c[2] = ~c[2];
            st_d[k][0] = c[0] ^ ror(c[0], 19) ^ ror(c[0], 28);
            st_d[k][1] = c[1] ^ ror(c[1], 61) ^ ror(c[1], 39);
            st_d[k][2] = c[2] ^ ror(c[2], 1)  ^ ror(c[2], 6);
            st_d[k][3] = c[3] ^ ror(c[3], 10) ^ ror(c[3], 17);
            st_d[k][4] = c[4] ^ ror(c[4], 7)  ^ ror(c[4], 41);
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            fsm        <= IDLE;
            rnd_idx    <= '0;
            st_q       <= '0;
            a_q        <= '0;
            dom_q      <= '0;
            rand_ready <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            done    <= 1'b0;
            cfg_err <= 1'b0;
            unique case (fsm)
                IDLE: begin
                    if (start) begin
                        if (rounds >= 4'd1 && rounds <= 4'd12) begin
                            st_q       <= state_in;
                            rnd_idx    <= 4'd12 - rounds;
                            busy       <= 1'b1;
                            rand_ready <= 1'b1;
                            fsm        <= RUN_A;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                RUN_A: begin
                    if (rand_valid) begin
                        a_q        <= a_d;
                        dom_q      <= dom_d;
                        rand_ready <= 1'b0;
                        fsm        <= RUN_B;
                    end
                end
                RUN_B: begin
                    st_q    <= st_d;
                    rnd_idx <= rnd_idx + 4'd1;
                    if (rnd_idx == 4'd11) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                        fsm  <= DONE;
                    end else begin
                        rand_ready <= 1'b1;
                        fsm        <= RUN_A;
                    end
                end
                DONE: begin
                    fsm <= IDLE;
`ifdef ASCON_DOM_ZEROIZE_EN
                    st_q    <= '0;
                    a_q     <= '0;
                    dom_q   <= '0;
                    rnd_idx <= '0;
`else
`endif
                end
                default: fsm <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ascon_perm_dom_iter.sv
// Directed bench: 2-share and 3-share permutation instances checked against
// an unmasked Ascon reference and hand-computed single-round values.
`timescale 1ns/1ps
module tb_ascon_perm_dom_iter;
    logic clk = 1'b0;
    logic RST;
    always #5 clk = ~clk;

    logic         start2, rv2, rr2, busy2, done2, cerr2;
    logic [3:0]   rounds2;
    logic [639:0] sin2, sout2;
    logic [319:0] rnd2;

    logic         start3, rv3, rr3, busy3, done3, cerr3;
    logic [3:0]   rounds3;
    logic [959:0] sin3, sout3;
    logic [959:0] rnd3;

    int vectors     = 0;
    int miscompares = 0;

    ascon_perm_dom_iter #(.NUM_SHARES(2)) dut2 (
        .clk(clk), .RST(RST), .start(start2), .rounds(rounds2),
        .state_in(sin2), .rand_in(rnd2), .rand_valid(rv2),
        .rand_ready(rr2), .state_out(sout2), .busy(busy2),
        .done(done2), .cfg_err(cerr2)
    );

    ascon_perm_dom_iter #(.NUM_SHARES(3)) dut3 (
        .clk(clk), .RST(RST), .start(start3), .rounds(rounds3),
        .state_in(sin3), .rand_in(rnd3), .rand_valid(rv3),
        .rand_ready(rr3), .state_out(sout3), .busy(busy3),
        .done(done3), .cfg_err(cerr3)
    );

    task automatic chk(input string tag, input logic [319:0] obs,
                       input logic [319:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int w = 0; w < 10; w++) rnd2[32*w +: 32] = $urandom;
        for (int w = 0; w < 30; w++) rnd3[32*w +: 32] = $urandom;
    endtask

    function automatic logic [319:0] rand320();
        logic [319:0] v;
        for (int w = 0; w < 10; w++) v[32*w +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [63:0] rr(input logic [63:0] x, input int n);
        logic [127:0] d;
        d = {x, x} >> n;
        return d[63:0];
    endfunction

    function automatic logic [319:0] ascon_ref(input logic [319:0] s,
                                               input int nr);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        {x4, x3, x2, x1, x0} = s;
        for (int r = 12 - nr; r < 12; r++) begin
            x2 ^= {56'd0, 4'(15 - r), 4'(r)};
            x0 ^= x4; x4 ^= x3; x2 ^= x1;
            t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3;
            t3 = ~x3 & x4; t4 = ~x4 & x0;
            x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
            x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
            x0 ^= rr(x0, 19) ^ rr(x0, 28);
            x1 ^= rr(x1, 61) ^ rr(x1, 39);
            x2 ^= rr(x2, 1)  ^ rr(x2, 6);
            x3 ^= rr(x3, 10) ^ rr(x3, 17);
            x4 ^= rr(x4, 7)  ^ rr(x4, 41);
        end
        return {x4, x3, x2, x1, x0};
    endfunction

    function automatic logic [319:0] xs2(input logic [639:0] v);
        return v[319:0] ^ v[639:320];
    endfunction

    function automatic logic [319:0] xs3(input logic [959:0] v);
        return v[319:0] ^ v[639:320] ^ v[959:640];
    endfunction

    task automatic run2(input logic [639:0] s, input logic [3:0] r,
                        output logic [639:0] res, output int cyc);
        sin2 = s; rounds2 = r; start2 = 1'b1;
        tick();
        start2 = 1'b0;
        cyc = 0;
        while (done2 !== 1'b1 && cyc < 200) begin
            tick();
            cyc++;
        end
        res = sout2;
    endtask

    initial begin
        logic [639:0] res, res_b;
        logic [959:0] res3;
        logic [319:0] st, r1, r2, snap;
        int cyc;

        RST = 1'b1;
        start2 = 1'b0; rounds2 = '0; sin2 = '0; rnd2 = '0; rv2 = 1'b1;
        start3 = 1'b0; rounds3 = '0; sin3 = '0; rnd3 = '0; rv3 = 1'b1;
        tick(); tick();
        RST = 1'b0;
        tick();
        chk("rst_state_out", sout2[319:0] | sout2[639:320], '0);
        chk("rst_flags", 320'({busy2, done2, rr2, cerr2}), '0);

        // Reset in the middle of RUN_B
        st = rand320();
        sin2 = {st, ~st}; rounds2 = 4'd12; start2 = 1'b1;
        tick();
        start2 = 1'b0;
        tick();
        RST = 1'b1;
        tick();
        chk("midrst_state_out", sout2[319:0] | sout2[639:320], '0);
        chk("midrst_flags", 320'({busy2, done2, rr2}), '0);
        RST = 1'b0;
        tick();

        // Zero known answer, 12 rounds
        run2('0, 4'd12, res, cyc);
        chk("kat12_latency", 320'(cyc), 320'(24));
        chk("kat12_result", xs2(res), ascon_ref('0, 12));
        tick();
        chk("done_one_cycle", 320'({done2, busy2}), '0);
`ifdef ASCON_DOM_ZEROIZE_EN
        chk("zeroize_after_done", sout2[319:0] | sout2[639:320], '0);
`else
        chk("hold_after_done", xs2(sout2), xs2(res));
`endif

        // Single round on zero state: hand-derived column values
        run2('0, 4'd1, res, cyc);
        chk("r1_latency", 320'(cyc), 320'(2));
        chk("r1_x0", 320'(xs2(res)[63:0]), 320'(64'h0009_64B0_0000_004B));
        chk("r1_x1", 320'(xs2(res)[127:64]), 320'(64'h0000_0000_9600_0213));
        chk("r1_x2", 320'(xs2(res)[191:128]), 320'(64'h53FF_FFFF_FFFF_FF90));
        chk("r1_x3", 320'(xs2(res)[255:192]), 320'(64'h12E5_8000_0000_004B));
        chk("r1_x4", 320'(xs2(res)[319:256]), '0);
        tick();

        // Masked inputs, 6 and 8 rounds, two different masks
        st = rand320(); r1 = rand320(); r2 = rand320();
        run2({r1, st ^ r1}, 4'd6, res, cyc);
        chk("p6_result", xs2(res), ascon_ref(st, 6));
        tick();
        run2({r1, st ^ r1}, 4'd8, res, cyc);
        chk("p8_latency", 320'(cyc), 320'(16));
        chk("p8_result", xs2(res), ascon_ref(st, 8));
        tick();
        run2({r2, st ^ r2}, 4'd8, res_b, cyc);
        chk("p8_remask_result", xs2(res_b), ascon_ref(st, 8));
        chk("p8_remask_shares_differ",
            320'(res_b[319:0] !== res[319:0]), 320'(1));
        tick();

        // Randomness stall of 5 cycles in round 3
        st = rand320(); r1 = rand320();
        sin2 = {r1, st ^ r1}; rounds2 = 4'd12; start2 = 1'b1;
        tick();
        start2 = 1'b0;
        cyc = 0;
        repeat (4) begin tick(); cyc++; end
        rv2 = 1'b0;
        snap = xs2(sout2);
        repeat (5) begin tick(); cyc++; end
        chk("stall_frozen", xs2(sout2), snap);
        chk("stall_ready_held", 320'({rr2, busy2}), 320'(2'b11));
        rv2 = 1'b1;
        while (done2 !== 1'b1 && cyc < 200) begin tick(); cyc++; end
        chk("stall_latency", 320'(cyc), 320'(29));
        chk("stall_result", xs2(sout2), ascon_ref(st, 12));
        res = sout2;
        tick();

        // Illegal round counts
        sin2 = {rand320(), rand320()}; rounds2 = 4'd0; start2 = 1'b1;
        tick();
        start2 = 1'b0;
        chk("r0_cfg_err", 320'({cerr2, busy2, rr2}), 320'(3'b100));
        tick();
        chk("r0_cfg_err_pulse", 320'(cerr2), '0);
        rounds2 = 4'd13; start2 = 1'b1;
        tick();
        start2 = 1'b0;
        chk("r13_cfg_err", 320'({cerr2, busy2}), 320'(2'b10));
`ifdef ASCON_DOM_ZEROIZE_EN
        chk("cfg_err_state_kept", sout2[319:0] | sout2[639:320], '0);
`else
        chk("cfg_err_state_kept", xs2(sout2), xs2(res));
`endif
        tick();

        // Start while busy is ignored
        st = rand320(); r1 = rand320();
        sin2 = {r1, st ^ r1}; rounds2 = 4'd4; start2 = 1'b1;
        tick();
        start2 = 1'b0;
        cyc = 0;
        tick(); cyc++;
        sin2 = '1; rounds2 = 4'd1; start2 = 1'b1;
        tick(); cyc++;
        tick(); cyc++;
        start2 = 1'b0;
        while (done2 !== 1'b1 && cyc < 200) begin tick(); cyc++; end
        chk("busy_start_latency", 320'(cyc), 320'(8));
        chk("busy_start_result", xs2(sout2), ascon_ref(st, 4));
        tick();

        // Three shares, 12 rounds
        st = rand320(); r1 = rand320(); r2 = rand320();
        sin3 = {r2, r1, st ^ r1 ^ r2}; rounds3 = 4'd12; start3 = 1'b1;
        tick();
        start3 = 1'b0;
        cyc = 0;
        while (done3 !== 1'b1 && cyc < 200) begin tick(); cyc++; end
        res3 = sout3;
        chk("ns3_latency", 320'(cyc), 320'(24));
        chk("ns3_result", xs3(res3), ascon_ref(st, 12));
        tick();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
